// File: rtl/acq_pkg.sv
// +----------------------------------------------------------------------------+
// | acq_pkg                                                                    |
// | Shared state encoding and counter widths for the acquisition sequencer.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package acq_pkg;

    localparam int ARM_CNT_W     = 16;
    localparam int TIMEOUT_CNT_W = 16;
    localparam int TIMER_W       = (ARM_CNT_W > TIMEOUT_CNT_W) ? ARM_CNT_W : TIMEOUT_CNT_W;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARMING     = 3'd1,
        READY_WAIT = 3'd2,
        CAPTURE    = 3'd3,
        PAUSED     = 3'd4
    } acq_state_e;

endpackage

`default_nettype wire

// File: rtl/acq_timer.sv
// +----------------------------------------------------------------------------+
// | acq_timer                                                                  |
// | Loadable down-counter with zero flag; serves the arm delay and go watchdog.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module acq_timer
    import acq_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Counts down freely and parks at zero; owners only look at it right after a load.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/acq_sequencer.sv
// +----------------------------------------------------------------------------+
// | acq_sequencer                                                              |
// | Front-end side of the prepare/go/pause trigger handshake driving a         |
// | fixed-length sample-buffer capture. Optional macro ACQ_TIMEOUT_EN adds a   |
// | READY_WAIT go watchdog and the sticky timeout_err output.                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module acq_sequencer
    import acq_pkg::*;
#(
    parameter int ARM_CYCLES  = 16,
    parameter int NUM_SAMPLES = 1024,
    parameter int ADDR_W      = 10,
    parameter int GO_TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prepare,
    input  logic              go,
    input  logic              pause,
    output logic              ready,
    output logic              done,
    output logic              busy,
    output logic              adc_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
`ifdef ACQ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

    acq_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              adc_en_q, adc_en_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_zero;

`ifdef ACQ_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;
`else
    // GO_TIMEOUT only matters when the watchdog is built in.
    logic [TIMER_W-1:0] unused_go_timeout;
    assign unused_go_timeout = TIMER_W'(GO_TIMEOUT);
`endif

    acq_timer #(
        .WIDTH    (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d        = state_q;
        ready_d        = 1'b0;
        done_d         = 1'b0;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        timer_load     = 1'b0;
        timer_load_val = TIMER_W'(ARM_CYCLES - 1);
`ifdef ACQ_TIMEOUT_EN
        timeout_err_d  = timeout_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (prepare) begin
                    state_d    = ARMING;
                    timer_load = 1'b1;
`ifdef ACQ_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                end
            end
            ARMING: begin
                if (timer_zero) begin
                    ready_d = 1'b1;
                    state_d = READY_WAIT;
`ifdef ACQ_TIMEOUT_EN
                    timer_load     = 1'b1;
                    timer_load_val = TIMER_W'(GO_TIMEOUT - 1);
`endif
                end
            end
            READY_WAIT: begin
                if (go) begin
                    state_d = pause ? PAUSED : CAPTURE;
                end
`ifdef ACQ_TIMEOUT_EN
                else if (timer_zero) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            CAPTURE: begin
                // wr_en_q high means the write at wr_addr_q completes on this edge.
                if (done_q) begin
                    state_d = IDLE;
                end else if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                    done_d    = 1'b1;
                    wr_addr_d = '0;
                end else begin
                    if (wr_en_q) begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                    if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        wr_en_d = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = CAPTURE;
                    wr_en_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The done cycle still counts as busy; IDLE is entered one cycle later.
        busy_d   = (state_d != IDLE);
        adc_en_d = busy_d & ~done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            adc_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            adc_en_q  <= adc_en_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

`ifdef ACQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign ready   = ready_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign adc_en  = adc_en_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_acq_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_acq_sequencer                                                           |
// | Self-checking bench for acq_sequencer; define ACQ_TIMEOUT_EN to also       |
// | exercise the go watchdog.                                                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_acq_sequencer;

    localparam int ARM = 16;
    localparam int NUM = 1024;
    localparam int AW  = 10;
    localparam int GTO = 50;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          prepare = 1'b0;
    logic          go      = 1'b0;
    logic          pause   = 1'b0;
    logic          ready, done, busy, adc_en, wr_en;
    logic [AW-1:0] wr_addr;
`ifdef ACQ_TIMEOUT_EN
    logic          timeout_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW+4:0] obs;
    logic [AW+4:0] expv;
    assign obs = {ready, done, busy, adc_en, wr_en, wr_addr};

    acq_sequencer #(
        .ARM_CYCLES  (ARM),
        .NUM_SAMPLES (NUM),
        .ADDR_W      (AW),
        .GO_TIMEOUT  (GTO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prepare     (prepare),
        .go          (go),
        .pause       (pause),
        .ready       (ready),
        .done        (done),
        .busy        (busy),
        .adc_en      (adc_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr)
`ifdef ACQ_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL global_time_limit cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full acquisition. Expected capture behaviour: after each edge,
    // wr_en is the complement of the sampled pause and wr_addr is the number
    // of samples already written; done follows the edge that ends the last write.
    task automatic run_acq(input int go_dly, input int pct, input bit go_pause,
                           input int hold_at, input int abort_at,
                           input bit noise, input bit fin_pause);
        int k, npause, m_edge, guard, hold_left;
        bit p, held;
        k = 0; npause = 0; guard = 0; hold_left = 0; held = 1'b0;

        prepare = 1'b1;
        for (int i = 0; i <= ARM; i++) begin
            step();
            prepare = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            total++;
            expv = {1'(i == ARM), 1'b0, 1'b1, 1'b1, 1'b0, AW'(0)};
            if (obs !== expv) begin
                bad++;
                $display("FAIL arm_phase cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end

        for (int d = 1; d < go_dly; d++) begin
            step();
            prepare = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            total++;
            expv = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, AW'(0)};
            if (obs !== expv) begin
                bad++;
                $display("FAIL ready_wait cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end

        go = 1'b1; pause = go_pause; prepare = 1'b0;
        step();
        go = 1'b0;
        m_edge = cyc;
        total++;
        expv = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, AW'(0)};
        if (obs !== expv) begin
            bad++;
            $display("FAIL go_accept cyc=%0d got=%h want=%h", cyc, obs, expv);
        end

        while (k < NUM && guard < 4 * NUM) begin
            if (!held && hold_at >= 0 && k == hold_at) begin
                held = 1'b1;
                hold_left = 5;
            end
            if (hold_left > 0) begin
                p = 1'b1;
                hold_left--;
            end else if (go_pause && guard < 3) begin
                p = 1'b1;
            end else begin
                p = ($urandom_range(0, 99) < pct);
            end
            pause = p;
            prepare = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            guard++;
            total++;
            expv = {1'b0, 1'b0, 1'b1, 1'b1, ~p, AW'(k)};
            if (obs !== expv) begin
                bad++;
                $display("FAIL capture cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
            if (abort_at >= 0 && !p && k == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                total++;
                if (obs !== '0) begin
                    bad++;
                    $display("FAIL async_reset got=%h want=0", obs);
                end
                pause = 1'b0; prepare = 1'b0;
                repeat (3) begin
                    step();
                    total++;
                    if (obs !== '0) begin
                        bad++;
                        $display("FAIL reset_hold cyc=%0d got=%h want=0", cyc, obs);
                    end
                end
                @(negedge clk);
                rst_n = 1'b1;
                step();
                total++;
                if (obs !== '0) begin
                    bad++;
                    $display("FAIL reset_release cyc=%0d got=%h want=0", cyc, obs);
                end
                return;
            end
            if (p) npause++;
            else   k++;
        end

        if (k < NUM) begin
            total++;
            bad++;
            $display("FAIL capture_budget written=%0d want=%0d", k, NUM);
            @(negedge clk); rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
            pause = 1'b0; prepare = 1'b0;
            return;
        end

        pause = fin_pause; prepare = 1'b0;
        step();
        total++;
        expv = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, AW'(0)};
        if (obs !== expv) begin
            bad++;
            $display("FAIL done_pulse cyc=%0d got=%h want=%h", cyc, obs, expv);
        end
        total++;
        if (cyc !== m_edge + NUM + npause + 1) begin
            bad++;
            $display("FAIL done_edge got=%0d want=%0d", cyc, m_edge + NUM + npause + 1);
        end

        // prepare landing in the done cycle must be ignored
        pause = 1'b0; prepare = noise;
        step();
        prepare = 1'b0;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL return_idle cyc=%0d got=%h want=0", cyc, obs);
        end
        step();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL stay_idle cyc=%0d got=%h want=0", cyc, obs);
        end
`ifdef ACQ_TIMEOUT_EN
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err_quiet got=%b want=0", timeout_err);
        end
`endif
    endtask

    task automatic test_reset();
        prepare = 1'b1; go = 1'b1; pause = 1'b1;
        repeat (2) begin
            step();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_state got=%h want=0", obs);
            end
`ifdef ACQ_TIMEOUT_EN
            total++;
            if (timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL reset_timeout_err got=%b want=0", timeout_err);
            end
`endif
        end
        prepare = 1'b0; go = 1'b0; pause = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_release_idle got=%h want=0", obs);
        end
    endtask

    task automatic test_ignored_go();
        for (int i = 0; i < 8; i++) begin
            go    = 1'($urandom_range(0, 1));
            pause = 1'($urandom_range(0, 1));
            step();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL idle_go_ignored cyc=%0d got=%h want=0", cyc, obs);
            end
        end
        go = 1'b0; pause = 1'b0;
    endtask

    task automatic test_handshake();
        run_acq(4, 0, 1'b0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_pause();
        run_acq(3, 0, 1'b0, 100, -1, 1'b0, 1'b1);
    endtask

    task automatic test_ignored_prepare();
        run_acq(5, 0, 1'b0, -1, -1, 1'b1, 1'b0);
    endtask

    task automatic test_go_pause();
        run_acq(2, 0, 1'b1, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_acq(6, 0, 1'b0, -1, 500, 1'b0, 1'b0);
        run_acq(1, 0, 1'b0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
`ifdef ACQ_TIMEOUT_EN
        prepare = 1'b1;
        step();
        prepare = 1'b0;
        repeat (ARM) step();
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL to_ready got=%b want=1", ready);
        end
        for (int i = 1; i <= GTO; i++) begin
            step();
            total++;
            if ({ready, done, busy, adc_en, wr_en, timeout_err} !==
                {1'b0, 1'b0, 1'(i < GTO), 1'(i < GTO), 1'b0, 1'(i == GTO)}) begin
                bad++;
                $display("FAIL watchdog i=%0d got r/d/b/a/w/t=%b%b%b%b%b%b", i,
                         ready, done, busy, adc_en, wr_en, timeout_err);
            end
        end
        repeat (3) step();
        total++;
        if ({busy, timeout_err} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_sticky got=%b%b want=01", busy, timeout_err);
        end
        prepare = 1'b1;
        step();
        prepare = 1'b0;
        total++;
        if ({busy, adc_en, timeout_err} !== 3'b110) begin
            bad++;
            $display("FAIL timeout_clear got=%b%b%b want=110", busy, adc_en, timeout_err);
        end
        repeat (ARM + GTO) step();
        total++;
        if ({busy, timeout_err} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_again got=%b%b want=01", busy, timeout_err);
        end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            run_acq(int'($urandom_range(1, 20)), int'($urandom_range(5, 40)),
                    1'($urandom_range(0, 1)), -1, -1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_ignored_go();
        test_handshake();
        test_pause();
        test_ignored_prepare();
        test_go_pause();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
